// File: rtl/prog_mem_loader_if.sv
// Host-to-loader program stream: one word per valid/ready transfer, with
// ld_last marking the final word of the program.
interface prog_mem_loader_if #(
    parameter int DW = 16
);
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;

    modport master (
        output ld_valid,
        output ld_data,
        output ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid,
        input  ld_data,
        input  ld_last,
        output ld_ready
    );
endinterface

// File: rtl/prog_mem_loader.sv
// Program memory in front of the core: loads a program from a host stream,
// keeps the core stalled while loading, then serves zero-latency reads.
module prog_mem_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 7,
    parameter int DW    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    prog_mem_loader_if.slave    ld,
    input  logic [AW-1:0]       proc_addr,
    output logic [DW-1:0]       proc_data,
    output logic                proc_run,
    output logic                done,
    output logic [AW:0]         count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [AW:0] LP_DEPTH = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LP_ONE   = (AW + 1)'(1);

    state_t        r_state;
    state_t        w_next_state;
    logic [AW:0]   r_count;
    logic [AW:0]   w_next_count;
    logic          r_done;
    logic          w_next_done;
    logic          w_ready;
    logic          w_xfer;
    logic          w_rd_hit;
    logic [DW-1:0] r_mem [DEPTH];

    assign w_ready = (r_state == LOAD) && (r_count < LP_DEPTH);

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_next_done  = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = LOAD;
                    w_next_count = '0;
                end
            end
            LOAD: begin
                if (ld.ld_valid && w_ready) begin
                    w_xfer       = 1'b1;
                    w_next_count = r_count + LP_ONE;
                    // Filling the last slot ends the load even without ld_last.
                    if (ld.ld_last || (w_next_count == LP_DEPTH)) begin
                        w_next_state = RUN;
                        w_next_done  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (start) begin
                    w_next_state = LOAD;
                    w_next_count = '0;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_count = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            r_done  <= w_next_done;
        end
    end

    // Storage is deliberately not reset; the count gate below hides stale words.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            r_mem[r_count[AW-1:0]] <= ld.ld_data;
        end
    end

    assign w_rd_hit    = (r_state == RUN) && ({1'b0, proc_addr} < r_count);
    assign proc_data   = w_rd_hit ? r_mem[proc_addr] : '0;
    assign proc_run    = (r_state == RUN);
    assign done        = r_done;
    assign count       = r_count;
    assign ld.ld_ready = w_ready;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Self-checking bench for prog_mem_loader: directed vector tables, hand-written
// corner sequences and randomized programs against a behavioural program model.
module tb_prog_mem_loader;

    localparam int AW    = 7;
    localparam int DW    = 16;
    localparam int DEPTH = 128;

    typedef struct {
        logic          st;
        logic          v;
        logic [DW-1:0] d;
        logic          l;
        logic          expReady;
        logic          expDone;
        logic          expRun;
        logic [AW:0]   expCount;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] expData;
    } rd_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] procAddr = '0;
    logic [DW-1:0] procData;
    logic          procRun;
    logic          done;
    logic [AW:0]   count;

    int nCompared   = 0;
    int nMismatched = 0;

    // The model only knows "which program words were accepted" and whether
    // the core is running; reads are answered from that program array.
    logic [DW-1:0] modelProg [DEPTH];
    int            modelCount   = 0;
    bit            modelLoading = 1'b0;
    bit            modelRunning = 1'b0;
    bit            modelDone    = 1'b0;

    prog_mem_loader_if #(.DW(DW)) ldIf ();

    prog_mem_loader #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ld        (ldIf.slave),
        .proc_addr (procAddr),
        .proc_data (procData),
        .proc_run  (procRun),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] modelRead(input int addr);
        if (modelRunning && addr < modelCount) return modelProg[addr];
        return '0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        modelCount   = 0;
        modelLoading = 1'b0;
        modelRunning = 1'b0;
        modelDone    = 1'b0;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, " ld_ready"}, 32'(ldIf.ld_ready), 32'(modelLoading && modelCount < DEPTH));
        checkOutput({tag, " proc_run"}, 32'(procRun), 32'(modelRunning));
        checkOutput({tag, " done"}, 32'(done), 32'(modelDone));
        checkOutput({tag, " count"}, 32'(count), 32'(modelCount));
        if ($urandom_range(0, 3) == 0) procAddr = AW'($urandom_range(0, DEPTH - 1));
        else procAddr = AW'($urandom_range(0, (modelCount > 0) ? modelCount : 0) % DEPTH);
        #1;
        checkOutput({tag, " proc_data"}, 32'(procData), 32'(modelRead(int'(procAddr))));
    endtask

    // One clock of host stimulus; the model advances at the same edge.
    task automatic applyStimulus(input logic st, input logic v, input logic [DW-1:0] d,
                                 input logic l, input string tag);
        start         = st;
        ldIf.ld_valid = v;
        ldIf.ld_data  = d;
        ldIf.ld_last  = l;
        @(posedge clk);
        modelDone = 1'b0;
        if (modelLoading) begin
            if (v && modelCount < DEPTH) begin
                modelProg[modelCount] = d;
                modelCount++;
                if (l || modelCount == DEPTH) begin
                    modelLoading = 1'b0;
                    modelRunning = 1'b1;
                    modelDone    = 1'b1;
                end
            end
        end else if (st) begin
            modelLoading = 1'b1;
            modelRunning = 1'b0;
            modelCount   = 0;
        end
        #1;
        checkModel(tag);
    endtask

    task automatic checkRead(input logic [AW-1:0] addr, input logic [DW-1:0] exp, input string tag);
        procAddr = addr;
        #1;
        checkOutput(tag, 32'(procData), 32'(exp));
    endtask

    vec_t shortVecs [5];
    rd_t  shortReads [5];

    initial begin
        shortVecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        shortVecs[1] = '{1'b0, 1'b1, 16'h1041, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        shortVecs[2] = '{1'b0, 1'b1, 16'h0208, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        shortVecs[3] = '{1'b0, 1'b1, 16'h4005, 1'b1, 1'b0, 1'b1, 1'b1, 8'd3};
        shortVecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3};
        shortReads[0] = '{7'd0,   16'h1041};
        shortReads[1] = '{7'd1,   16'h0208};
        shortReads[2] = '{7'd2,   16'h4005};
        shortReads[3] = '{7'd3,   16'h0000};
        shortReads[4] = '{7'd127, 16'h0000};

        ldIf.ld_valid = 1'b0;
        ldIf.ld_data  = '0;
        ldIf.ld_last  = 1'b0;
        modelReset();

        // Reset held for two cycles, then IDLE must ignore a valid host.
        repeat (2) @(posedge clk);
        #1;
        checkModel("reset");
        #2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 16'h1234 + 16'(i), 1'b0, "idle");

        // Short program from the vector table.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(shortVecs[i].st, shortVecs[i].v, shortVecs[i].d, shortVecs[i].l, "short");
            checkOutput($sformatf("vec%0d ready", i), 32'(ldIf.ld_ready), 32'(shortVecs[i].expReady));
            checkOutput($sformatf("vec%0d done", i), 32'(done), 32'(shortVecs[i].expDone));
            checkOutput($sformatf("vec%0d run", i), 32'(procRun), 32'(shortVecs[i].expRun));
            checkOutput($sformatf("vec%0d count", i), 32'(count), 32'(shortVecs[i].expCount));
        end
        for (int i = 0; i < 5; i++)
            checkRead(shortReads[i].addr, shortReads[i].expData, $sformatf("short read%0d", i));

        // Reload from RUN with a single word.
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, "reload start");
        checkOutput("reload run low", 32'(procRun), 32'(1'b0));
        checkRead(7'd0, 16'h0000, "reload read in LOAD");
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1, "reload word");
        checkOutput("reload count", 32'(count), 32'(1));
        checkRead(7'd0, 16'hFFFF, "reload addr0");
        checkRead(7'd1, 16'h0000, "reload addr1");

        // Stalled host: garbage on idle cycles must never be written.
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, "stall start");
        applyStimulus(1'b0, 1'b1, 16'h000A, 1'b0, "stall");
        applyStimulus(1'b0, 1'b0, 16'hDEAD, 1'b0, "stall");
        applyStimulus(1'b0, 1'b0, 16'hBEEF, 1'b1, "stall");
        applyStimulus(1'b0, 1'b1, 16'h000B, 1'b0, "stall");
        applyStimulus(1'b0, 1'b1, 16'h000C, 1'b1, "stall");
        checkOutput("stall count", 32'(count), 32'(3));
        checkRead(7'd1, 16'h000B, "stall mem1");
        checkRead(7'd2, 16'h000C, "stall mem2");

        // Full depth without ld_last.
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, "full start");
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 16'(i), 1'b0, "full");
        checkOutput("full run", 32'(procRun), 32'(1'b1));
        checkOutput("full count", 32'(count), 32'(128));
        checkOutput("full ready", 32'(ldIf.ld_ready), 32'(1'b0));
        checkRead(7'd127, 16'd127, "full addr127");
        applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b1, "full extra");
        checkOutput("full extra count", 32'(count), 32'(128));
        checkRead(7'd127, 16'd127, "full extra addr127");

        // Randomized programs with host gaps, ignored starts and stray ld_last.
        for (int p = 0; p < 10; p++) begin
            int len;
            len = $urandom_range(1, 12);
            applyStimulus(1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, "rand start");
            for (int c = 0; c < 200 && modelLoading; c++) begin
                logic v;
                v = ($urandom_range(0, 3) != 0);
                applyStimulus(($urandom_range(0, 7) == 0), v, 16'($urandom),
                              v ? (modelCount == len - 1) : 1'($urandom_range(0, 1)), "rand");
            end
            checkOutput("rand final count", 32'(count), 32'(len));
            repeat (3) applyStimulus(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 1'b0, "rand run");
        end

        // Asynchronous reset in the middle of a load.
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, "abort start");
        applyStimulus(1'b0, 1'b1, 16'h1111, 1'b0, "abort");
        applyStimulus(1'b0, 1'b1, 16'h2222, 1'b0, "abort");
        ldIf.ld_valid = 1'b0;
        #2;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("abort count", 32'(count), 32'(0));
        checkOutput("abort ready", 32'(ldIf.ld_ready), 32'(1'b0));
        checkOutput("abort done", 32'(done), 32'(1'b0));
        checkOutput("abort run", 32'(procRun), 32'(1'b0));
        @(posedge clk);
        #3;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b1, 16'h3333, 1'b0, "abort idle");
        checkRead(7'd0, 16'h0000, "abort read0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- Program memory and loader that sits directly upstream of the processor core.
- It drives the core's 16-bit instruction/data input from the core's 7-bit address.
- Before execution, it accepts a program stream from a host over a valid/ready handshake.
- It holds the core stalled until loading completes, then releases it to run.

Parameters:
DEPTH, 128, number of 16-bit words; must equal 2**AW
AW, 7, address width; matches the core's addr port
DW, 16, word width; matches the core's d_in port

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle request to begin a (re)load
ld_valid  input  1  host word valid
ld_data  input  DW  host word
ld_last  input  1  qualifies the current ld_data as the final word of the program
ld_ready  output  1  loader can accept a word this cycle
proc_addr  input  AW  address from the core
proc_data  output  DW  word to the core's d_in
proc_run  output  1  high = core may execute; top level gates the core's reset with it
done  output  1  one-cycle pulse when loading finishes
count  output  AW+1  number of words loaded, 0..DEPTH

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - count=0, proc_run=0, done=0, ld_ready=0.
  - Memory array is not reset.
- States: IDLE, LOAD, RUN. State and count are registered and update on the rising clk edge.
- IDLE:
  - ld_ready=0; ld_valid is ignored.
  - start=1 moves to LOAD on the next edge and clears count to 0.
- LOAD:
  - ld_ready=1 whenever count<DEPTH; it is a registered-state decode, not combinational from ld_valid.
  - A transfer occurs when ld_valid=1 and ld_ready=1 at an edge. It writes mem[count[AW-1:0]]<=ld_data and increments count.
  - Move to RUN at the edge of a transfer with ld_last=1.
  - Move to RUN at the edge of the transfer that makes count==DEPTH, regardless of ld_last.
  - On that edge, done is registered to 1 for exactly one cycle.
  - start is ignored while in LOAD.
  - If ld_last=1 with ld_valid=0, nothing happens.
- RUN:
  - proc_run=1 (registered; rises the cycle after the final transfer, coincident with done) and ld_ready=0.
  - start=1 returns to LOAD on the next edge: count clears and proc_run falls on that same edge.
  - Memory contents are kept until overwritten.
- Read path: combinational, zero latency.
  - proc_data = mem[proc_addr] when proc_run=1 and proc_addr<count.
  - Otherwise proc_data=16'h0000. This covers non-RUN states and unloaded words, so memory is never read uninitialised.
- Empty program: not possible. LOAD exits only via a transfer, so count is at least 1 in RUN.
- Reset mid-LOAD: state aborts to IDLE and count=0. Words already written remain, but read as 0 because count=0.
- count width is AW+1 so the value DEPTH is representable. There is no wrap; a transfer is never accepted at count==DEPTH.
- No write path from the core; d_out is not consumed by this block.

Test Plan:
- Reset then IDLE:
  - Stimulus: reset low for 2 cycles, release; ld_valid=1 for 5 cycles with start=0.
  - Required: ld_ready=0, count=0, proc_run=0, proc_data=0 throughout.
- Short program:
  - Stimulus: start pulse; send 3 words 16'h1041, 16'h0208, 16'h4005 back-to-back, ld_last on the third.
  - Required: done pulses once the cycle after the third transfer; proc_run=1; count=3.
  - Required reads: proc_addr=0,1,2 read 16'h1041, 16'h0208, 16'h4005; proc_addr=3 and 127 read 16'h0000.
- Stalled host:
  - Stimulus: start; ld_valid toggled 1,0,0,1,1 with words 16'hA, 16'hB, 16'hC; ld_last on the last.
  - Required: exactly 3 writes, count=3; mem[1]=16'hB and no duplicate write during the gaps.
- Full depth:
  - Stimulus: start; 128 words of value i, ld_last never asserted.
  - Required: RUN entered after word 127; count=128; ld_ready=0; proc_addr=127 reads 16'd127; a 129th ld_valid is not accepted.
- Reload from RUN:
  - Stimulus: after the short program, pulse start; send 1 word 16'hFFFF with ld_last.
  - Required: proc_run drops the cycle after start and proc_data=0 while in LOAD.
  - Required after completion: count=1; addr0 reads 16'hFFFF; addr1 reads 0, although 16'h0208 is still stored.
- Reset mid-load:
  - Stimulus: start; 2 words sent; assert reset asynchronously between edges.
  - Required: state IDLE, count=0, ld_ready=0, done=0 immediately without waiting for a clk edge.
